servo_pulse_decoder: RTL and testbench

//  Receive-side counterpart of the servo PWM generator: measures an incoming servo-style

---
 rtl/servo_pulse_decoder_if.sv | 21 ++
 rtl/servo_pulse_decoder.sv | 165 ++++++++++++++++
 tb/tb_servo_pulse_decoder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/servo_pulse_decoder_if.sv
// Signal bundle between the servo pulse decoder and its surroundings.
// The master drives the enable and the raw pulse pin; the slave returns the measurement.
interface servo_pulse_decoder_if;
  logic        en;
  logic        pwm_in;
  logic [19:0] pulse_width;
  logic [10:0] duty_code;
  logic        sample_valid;
  logic        range_err;
  logic        signal_lost;

  modport master (
    output en, pwm_in,
    input  pulse_width, duty_code, sample_valid, range_err, signal_lost
  );

  modport slave (
    input  en, pwm_in,
    output pulse_width, duty_code, sample_valid, range_err, signal_lost
  );
endinterface

// File: rtl/servo_pulse_decoder.sv
// Measures a servo pulse train, validates period and width, and recovers the duty code
// (25..125). Flags rejected frames and loss of signal.
module servo_pulse_decoder #(
  parameter int PERIOD_CYCLES  = 1_000_000,
  parameter int PERIOD_TOL     = 50_000,
  parameter int MIN_PULSE      = 25_000,
  parameter int MAX_PULSE      = 125_000,
  parameter int WIDTH_TOL      = 5_000,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  servo_pulse_decoder_if.slave bus
);

  typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

  localparam logic [31:0] PER_LO  = 32'(PERIOD_CYCLES - PERIOD_TOL);
  localparam logic [31:0] PER_HI  = 32'(PERIOD_CYCLES + PERIOD_TOL);
  localparam logic [31:0] W_LO    = 32'(MIN_PULSE - WIDTH_TOL);
  localparam logic [31:0] W_HI    = 32'(MAX_PULSE + WIDTH_TOL);
  localparam logic [31:0] P_MIN   = 32'(MIN_PULSE);
  localparam logic [31:0] P_MAX   = 32'(MAX_PULSE);
  localparam logic [31:0] P_RANGE = 32'(MAX_PULSE - MIN_PULSE);
  localparam logic [31:0] P_HALF  = P_RANGE >> 1;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [20:0] CNT_MAX = '1;

  logic        r_s1, r_s2, r_s3;
  logic [1:0]  r_sync_vld;
  state_t      r_state, w_state_next;
  logic [20:0] r_high_cnt, r_per_cnt, r_silence;
  logic [19:0] r_pulse_width;
  logic [10:0] r_duty_code;
  logic        r_sample_valid, r_range_err, r_signal_lost;

  logic        w_rise, w_fall, w_edge, w_timeout, w_clear;
  logic        w_start, w_eval, w_high_inc, w_per_inc, w_ok;
  logic [31:0] w_per32, w_high32, w_wc, w_num;
  logic [19:0] w_pw;
  logic [10:0] w_duty;

  assign w_rise    = r_s2 & ~r_s3;
  assign w_fall    = ~r_s2 & r_s3;
  assign w_edge    = w_rise | w_fall;
  assign w_timeout = bus.en & ~w_edge & ({11'd0, r_silence} == TO_LAST);
  assign w_clear   = ~bus.en | w_timeout;

  // r_sync_vld marks when s2 holds a real pin sample rather than its reset zero,
  // so a pulse already high at reset release is not mistaken for a low level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_sync_vld <= 2'b00;
    end else begin
      r_s1       <= bus.pwm_in;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= WAIT_LOW;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_clear) begin
      w_state_next = WAIT_LOW;
    end else begin
      case (r_state)
        WAIT_LOW:  if (r_sync_vld[1] && !r_s2) w_state_next = WAIT_RISE;
        WAIT_RISE: if (w_rise) w_state_next = MEAS_HIGH;
        MEAS_HIGH: if (w_fall) w_state_next = MEAS_LOW;
        MEAS_LOW:  if (w_rise) w_state_next = MEAS_HIGH;
        default:   w_state_next = WAIT_LOW;
      endcase
    end
  end

  always_comb begin
    w_start    = 1'b0;
    w_eval     = 1'b0;
    w_high_inc = 1'b0;
    w_per_inc  = 1'b0;
    if (!w_clear) begin
      case (r_state)
        WAIT_RISE: w_start = w_rise;
        MEAS_HIGH: begin
          w_high_inc = ~w_fall;
          w_per_inc  = 1'b1;
        end
        MEAS_LOW: begin
          w_start   = w_rise;
          w_eval    = w_rise;
          w_per_inc = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_high_cnt <= '0;
      r_per_cnt  <= '0;
    end else if (w_start) begin
      r_high_cnt <= 21'd1;
      r_per_cnt  <= 21'd1;
    end else begin
      if (w_high_inc && r_high_cnt != CNT_MAX) r_high_cnt <= r_high_cnt + 21'd1;
      if (w_per_inc && r_per_cnt != CNT_MAX)   r_per_cnt  <= r_per_cnt + 21'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.en || w_edge) r_silence <= '0;
    else if (r_silence != CNT_MAX) r_silence <= r_silence + 21'd1;
  end

  // Width-to-code: clamp, then rounded division by the constant pulse range.
  assign w_per32  = {11'd0, r_per_cnt};
  assign w_high32 = {11'd0, r_high_cnt};
  assign w_ok     = (w_per32 >= PER_LO) && (w_per32 <= PER_HI) &&
                    (w_high32 >= W_LO) && (w_high32 <= W_HI);
  assign w_wc     = (w_high32 < P_MIN) ? P_MIN : ((w_high32 > P_MAX) ? P_MAX : w_high32);
  assign w_num    = (w_wc - P_MIN) * 32'd100 + P_HALF;
  assign w_duty   = 11'(32'd25 + w_num / P_RANGE);
  assign w_pw     = r_high_cnt[20] ? 20'hFFFFF : r_high_cnt[19:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pulse_width  <= '0;
      r_duty_code    <= '0;
      r_sample_valid <= 1'b0;
      r_range_err    <= 1'b0;
      r_signal_lost  <= 1'b0;
    end else begin
      r_sample_valid <= w_eval & w_ok;
      if (w_eval) begin
        if (w_ok) begin
          r_pulse_width <= w_pw;
          r_duty_code   <= w_duty;
          r_range_err   <= 1'b0;
          r_signal_lost <= 1'b0;
        end else begin
          r_range_err   <= 1'b1;
        end
      end else if (w_timeout) begin
        r_signal_lost <= 1'b1;
      end
    end
  end

  assign bus.pulse_width  = r_pulse_width;
  assign bus.duty_code    = r_duty_code;
  assign bus.sample_valid = r_sample_valid;
  assign bus.range_err    = r_range_err;
  assign bus.signal_lost  = r_signal_lost;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed plus randomized frames against a frame-level reference model of the decoder,
// run with scaled-down timing parameters.
module tb_servo_pulse_decoder;
  localparam int P    = 1000;
  localparam int PTOL = 50;
  localparam int MINP = 50;
  localparam int MAXP = 250;
  localparam int WTOL = 10;
  localparam int TO   = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  servo_pulse_decoder_if bus ();

  servo_pulse_decoder #(
    .PERIOD_CYCLES(P), .PERIOD_TOL(PTOL), .MIN_PULSE(MINP),
    .MAX_PULSE(MAXP), .WIDTH_TOL(WTOL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int strobe_cnt = 0;
  int last_strobe_cyc = -1;

  // model state
  int exp_strobes = 0;
  int exp_pw = 0, exp_duty = 0, exp_rerr = 0, exp_lost = 0;
  bit meas_active = 0;
  int prev_h = 0, prev_p = 0;
  int rise_cyc = 0, fall_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.sample_valid === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      last_strobe_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_duty(input int w);
    int  wc;
    real x;
    wc = (w < MINP) ? MINP : ((w > MAXP) ? MAXP : w);
    x  = (wc - MINP) * 100.0 / (MAXP - MINP);
    return 25 + $rtoi($floor(x + 0.5));
  endfunction

  task automatic check_outputs();
    chk("strobe_cnt", 32'(strobe_cnt), 32'(exp_strobes));
    chk("pulse_width", 32'(bus.pulse_width), 32'(exp_pw));
    chk("duty_code", 32'(bus.duty_code), 32'(exp_duty));
    chk("range_err", 32'(bus.range_err), 32'(exp_rerr));
    chk("signal_lost", 32'(bus.signal_lost), 32'(exp_lost));
  endtask

  // Drive a rising edge (called at a negedge); a measured frame in progress is judged here.
  task automatic rise_and_check();
    bit expect_strobe;
    bit ok;
    expect_strobe = 0;
    bus.pwm_in = 1'b1;
    rise_cyc = cyc + 1;
    if (meas_active) begin
      ok = (prev_p >= P - PTOL) && (prev_p <= P + PTOL) &&
           (prev_h >= MINP - WTOL) && (prev_h <= MAXP + WTOL);
      if (ok) begin
        expect_strobe = 1;
        exp_strobes++;
        exp_pw   = prev_h;
        exp_duty = model_duty(prev_h);
        exp_rerr = 0;
        exp_lost = 0;
      end else begin
        exp_rerr = 1;
      end
    end
    repeat (4) @(negedge clk);
    check_outputs();
    if (expect_strobe) chk("strobe_cycle", 32'(last_strobe_cyc), 32'(rise_cyc + 2));
  endtask

  task automatic frame(input int h, input int p);
    rise_and_check();
    meas_active = 1;
    prev_h = h;
    prev_p = p;
    repeat (h - 4) @(negedge clk);
    bus.pwm_in = 1'b0;
    fall_cyc = cyc + 1;
    repeat (p - h) @(negedge clk);
  endtask

  task automatic frame_en_drop(input int h, input int p);
    rise_and_check();
    repeat (16) @(negedge clk);
    bus.en = 1'b0;
    meas_active = 0;
    repeat (5) @(negedge clk);
    check_outputs();
    bus.en = 1'b1;
    repeat (h - 25) @(negedge clk);
    bus.pwm_in = 1'b0;
    fall_cyc = cyc + 1;
    repeat (p - h) @(negedge clk);
  endtask

  task automatic frame_rst(input int h, input int p);
    rise_and_check();
    repeat (16) @(negedge clk);
    rst = 1'b1;
    meas_active = 0;
    repeat (3) @(negedge clk);
    exp_pw = 0; exp_duty = 0; exp_rerr = 0; exp_lost = 0;
    check_outputs();
    rst = 1'b0;
    repeat (h - 23) @(negedge clk);
    bus.pwm_in = 1'b0;
    fall_cyc = cyc + 1;
    repeat (p - h) @(negedge clk);
  endtask

  task automatic silence_check();
    int target;
    int guard;
    target = fall_cyc + 2 + TO;
    guard = 0;
    while (cyc < target - 1 && guard < 3 * TO) begin
      @(negedge clk);
      guard++;
    end
    chk("timeout_wait", 32'(cyc), 32'(target - 1));
    chk("lost_before", 32'(bus.signal_lost), 32'(exp_lost));
    @(negedge clk);
    exp_lost = 1;
    meas_active = 0;
    chk("lost_at_timeout", 32'(bus.signal_lost), 32'd1);
    repeat (20) @(negedge clk);
    check_outputs();
  endtask

  initial begin
    bus.en = 1'b1;
    bus.pwm_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs();
    chk("reset_strobe", 32'(bus.sample_valid), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // nominal frames
    frame(100, 1000);
    frame(100, 1000);
    frame(100, 1000);
    // width boundaries and rounding
    frame(50, 1000);
    frame(250, 1000);
    frame(48, 1000);
    frame(99, 1000);
    frame(101, 1000);
    // rejected width, rejected period, recovery
    frame(400, 1000);
    frame(100, 1200);
    frame(150, 1000);
    frame(200, 1000);
    // randomized frames around the acceptance edges
    for (int i = 0; i < 8; i++) begin
      frame(int'($urandom_range(290, 30)), int'($urandom_range(1060, 940)));
    end
    frame(120, 1000);
    // loss of signal, then recovery
    silence_check();
    frame(120, 1000);
    frame(130, 1000);
    frame(140, 1000);
    // enable dropped mid-pulse
    frame_en_drop(100, 1000);
    frame(160, 1000);
    frame(170, 1000);
    // reset mid-pulse, pulse still high at reset release
    frame_rst(100, 1000);
    frame(180, 1000);
    frame(190, 1000);
    rise_and_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
